addsub_issue: RTL and testbench

ADDSUB_ISSUE -- requirements
Module: addsub_issue

---
 rtl/addsub_issue.sv | 168 ++++++++++++++++
 tb/tb_addsub_issue.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_issue.sv
// addsub_issue: queues {a,b,m} requests in a small FIFO, issues them one at a
// time to an external combinational 2-bit add/sub slice, and captures the
// slice result (plus a sign flag) in a valid/ready output register.
module addsub_issue #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_a,
  input  logic [1:0] in_b,
  input  logic       in_m,
  output logic [1:0] as_a,
  output logic [1:0] as_b,
  output logic       as_m,
  input  logic [1:0] as_s,
  input  logic       as_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_s,
  output logic       out_cout,
  output logic       out_neg
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // FIFO storage: one entry is {a, b, m}
  logic [4:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] state_q, state_d;
  logic [1:0] as_a_q, as_a_d;
  logic [1:0] as_b_q, as_b_d;
  logic       as_m_q, as_m_d;
  logic       out_valid_q, out_valid_d;
  logic [1:0] out_s_q, out_s_d;
  logic       out_cout_q, out_cout_d;
  logic       out_neg_q, out_neg_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full     = (cnt_q == FULL_CNT);
  assign empty    = (cnt_q == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;

  assign as_a      = as_a_q;
  assign as_b      = as_b_q;
  assign as_m      = as_m_q;
  assign out_valid = out_valid_q;
  assign out_s     = out_s_q;
  assign out_cout  = out_cout_q;
  assign out_neg   = out_neg_q;

  // Issue FSM: decides when to pop the FIFO and when to capture the slice result
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    as_a_d      = as_a_q;
    as_b_d      = as_b_q;
    as_m_d      = as_m_q;
    out_valid_d = out_valid_q;
    out_s_d     = out_s_q;
    out_cout_d  = out_cout_q;
    out_neg_d   = out_neg_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Slice has had a full cycle to settle on the registered operands.
        out_s_d     = as_s;
        out_cout_d  = as_cout;
        out_neg_d   = as_m_q && (as_a_q < as_b_q);
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!empty) begin
            pop     = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Operand register only changes when a request leaves the FIFO.
    if (pop) begin
      {as_a_d, as_b_d, as_m_d} = mem_q[rd_ptr_q];
    end
  end

  // FIFO pointer and occupancy bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO entry write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_a, in_b, in_m};
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      as_a_q      <= '0;
      as_b_q      <= '0;
      as_m_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_s_q     <= '0;
      out_cout_q  <= 1'b0;
      out_neg_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      as_a_q      <= as_a_d;
      as_b_q      <= as_b_d;
      as_m_q      <= as_m_d;
      out_valid_q <= out_valid_d;
      out_s_q     <= out_s_d;
      out_cout_q  <= out_cout_d;
      out_neg_q   <= out_neg_d;
    end
  end

endmodule

// File: tb/tb_addsub_issue.sv
// Bench for addsub_issue: directed vector table, backpressure/full, reset in
// HOLD, exhaustive operand sweep and a random stream, all scoreboarded.
module tb_addsub_issue;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_a, in_b;
  logic       in_m;
  logic [1:0] as_a, as_b;
  logic       as_m;
  logic [1:0] as_s;
  logic       as_cout;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_s;
  logic       out_cout;
  logic       out_neg;

  int tests = 0;
  int fails = 0;
  int n_acc = 0;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       m;
    logic [1:0] s;
    logic       cout;
    logic       neg;
  } vec_t;

  vec_t       vecs [8];
  logic [3:0] exp_q [$];
  logic       hold_prev = 1'b0;
  logic [8:0] prev_snap = '0;

  addsub_issue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_m(in_m),
    .as_a(as_a), .as_b(as_b), .as_m(as_m),
    .as_s(as_s), .as_cout(as_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_cout(out_cout), .out_neg(out_neg)
  );

  always #5 clk = ~clk;

  // Downstream slice: add gives sum mod 4 with carry, subtract gives |A-B|
  always_comb begin
    int sa;
    int sb;
    int r;
    sa = int'(as_a);
    sb = int'(as_b);
    if (as_m) begin
      r       = (sa >= sb) ? (sa - sb) : (sb - sa);
      as_s    = r[1:0];
      as_cout = 1'b0;
    end else begin
      r       = sa + sb;
      as_s    = r[1:0];
      as_cout = (r >= 4);
    end
  end

  // Expected {out_s, out_cout, out_neg} for one request
  function automatic logic [3:0] model(input int a, input int b, input int m);
    int s;
    int c;
    int n;
    if (m == 0) begin
      s = (a + b) % 4;
      c = ((a + b) >= 4) ? 1 : 0;
      n = 0;
    end else begin
      s = (a >= b) ? (a - b) : (b - a);
      c = 0;
      n = (a < b) ? 1 : 0;
    end
    return {s[1:0], c[0], n[0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: sees every handshake at the negedge preceding the edge that takes it
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_stable", 32'({out_s, out_cout, out_neg, as_a, as_b, as_m}), 32'(prev_snap));
      end
      hold_prev = out_valid && !out_ready;
      prev_snap = {out_s, out_cout, out_neg, as_a, as_b, as_m};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result_qsize", 32'(exp_q.size()), 32'd1);
        end else begin
          chk("out_result", 32'({out_s, out_cout, out_neg}), 32'(exp_q.pop_front()));
          n_acc++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(int'(in_a), int'(in_b), int'(in_m)));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Hold a request until it is taken; optionally randomise out_ready meanwhile
  task automatic push_hold(input logic [1:0] a, input logic [1:0] b, input logic m, input bit rnd);
    int  n;
    bit  hs;
    n        = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_m     = m;
    forever begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      hs = in_ready;
      cyc();
      n++;
      if (hs) break;
      if (n > 200) begin
        chk("push_timeout", 32'(n), 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Run until every queued request has been delivered
  task automatic drain(input bit rnd);
    int n;
    n = 0;
    while (exp_q.size() != 0 || out_valid) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      n++;
      if (n > 1000) begin
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        break;
      end
    end
    out_ready = 1'b1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd3, 2'd2, 1'b0, 2'd1, 1'b1, 1'b0};
    vecs[1] = '{2'd1, 2'd3, 1'b1, 2'd2, 1'b0, 1'b1};
    vecs[2] = '{2'd3, 2'd1, 1'b1, 2'd2, 1'b0, 1'b0};
    vecs[3] = '{2'd0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0};
    vecs[4] = '{2'd3, 2'd3, 1'b0, 2'd2, 1'b1, 1'b0};
    vecs[5] = '{2'd2, 2'd3, 1'b1, 2'd1, 1'b0, 1'b1};
    vecs[6] = '{2'd1, 2'd1, 1'b1, 2'd0, 1'b0, 1'b0};
    vecs[7] = '{2'd0, 2'd3, 1'b0, 2'd3, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b1;
    in_a      = 2'd2;
    in_b      = 2'd1;
    in_m      = 1'b0;
    out_ready = 1'b1;
    cyc();
    cyc();
    rst      = 1'b0;
    in_valid = 1'b0;

    // Reset values
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'({out_s, out_cout, out_neg}), 32'd0);
    chk("rst_as", 32'({as_a, as_b, as_m}), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rst_nothing_stored", 32'(out_valid), 32'd0);
    end

    // Directed table: latency of two edges and the captured values
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_a     = vecs[i].a;
      in_b     = vecs[i].b;
      in_m     = vecs[i].m;
      cyc();
      in_valid = 1'b0;
      chk("lat_t0", 32'(out_valid), 32'd0);
      cyc();
      chk("lat_t1", 32'(out_valid), 32'd0);
      cyc();
      chk("lat_t2", 32'(out_valid), 32'd1);
      chk("vec_s", 32'(out_s), 32'(vecs[i].s));
      chk("vec_cout", 32'(out_cout), 32'(vecs[i].cout));
      chk("vec_neg", 32'(out_neg), 32'(vecs[i].neg));
      cyc();
      chk("vec_accepted", 32'(out_valid), 32'd0);
    end

    // Backpressure: one held, four queued, sixth dropped, then one per two cycles
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_a     = 2'(k);
      in_b     = 2'(3 - (k % 4));
      in_m     = 1'(k % 2);
      cyc();
    end
    in_a = 2'd3;
    in_b = 2'd3;
    in_m = 1'b0;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    cyc();
    chk("full_in_ready_hold", 32'(in_ready), 32'd0);
    chk("full_held_valid", 32'(out_valid), 32'd1);
    chk("full_held_s", 32'(out_s), 32'(model(0, 3, 0) >> 2));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("throughput", 32'(out_valid), 32'((k % 2) == 0));
      cyc();
    end
    chk("bp_all_delivered", 32'(exp_q.size()), 32'd0);

    // Simultaneous push and pop with DEPTH-1 entries queued
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_a     = 2'(k + 1);
      in_b     = 2'(k);
      in_m     = 1'b1;
      cyc();
    end
    in_a      = 2'd0;
    in_b      = 2'd2;
    in_m      = 1'b1;
    out_ready = 1'b1;
    chk("fm1_ready_before", 32'(in_ready), 32'd1);
    cyc();
    chk("fm1_pushpop_count", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    in_a      = 2'd2;
    in_b      = 2'd3;
    in_m      = 1'b0;
    cyc();
    chk("fm1_now_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    drain(1'b0);

    // Reset while in HOLD with three requests queued
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_a     = 2'(3 - k);
      in_b     = 2'(k);
      in_m     = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    chk("prerst_hold", 32'(out_valid), 32'd1);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_a     = 2'd1;
    in_b     = 2'd1;
    in_m     = 1'b0;
    cyc();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("hrst_out_valid", 32'(out_valid), 32'd0);
    chk("hrst_in_ready", 32'(in_ready), 32'd1);
    chk("hrst_as", 32'({as_a, as_b, as_m}), 32'd0);
    chk("hrst_out", 32'({out_s, out_cout, out_neg}), 32'd0);
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("hrst_no_stale", 32'(out_valid), 32'd0);
    end

    // Exhaustive {a,b,m} sweep with random consumer stalls
    begin
      int base;
      logic [4:0] v;
      base = n_acc;
      for (int i = 0; i < 32; i++) begin
        v = 5'(i);
        push_hold(v[4:3], v[2:1], v[0], 1'b1);
      end
      drain(1'b1);
      chk("exh_count", 32'(n_acc - base), 32'd32);
    end

    // Random stream, long enough for several pointer wraps
    begin
      int base;
      base = n_acc;
      for (int i = 0; i < 48; i++) begin
        repeat ($urandom_range(0, 2)) begin
          out_ready = 1'($urandom_range(0, 1));
          cyc();
        end
        push_hold(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
      end
      drain(1'b1);
      chk("rand_count", 32'(n_acc - base), 32'd48);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
